// File: rtl/cmpp_pkg.sv
// Shared compare-to-predicate definitions: op encodings, arbiter pointer states
// and the guarded result helper.
package cmpp_pkg;

   // op[1:0] selects normal/inverted sense for each result; op[2] marks a no-op
   typedef enum logic [1:0] {
      CMP_NN = 2'b00,
      CMP_NI = 2'b01,
      CMP_IN = 2'b10,
      CMP_II = 2'b11
   } cmp_kind_e;

   localparam int OP_NOP_BIT  = 2;
   localparam int OP_INV0_BIT = 1;
   localparam int OP_INV1_BIT = 0;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   typedef enum logic {
      LAST_RQ0 = 1'b0,
      LAST_RQ1 = 1'b1
   } rr_state_e;

   function automatic logic cmp_bit(input logic pred, input logic outt, input logic inv);
      return pred & (outt ^ inv);
   endfunction

endpackage

// File: rtl/cmpp_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted requester.
//
//  state    | meaning
//  LAST_RQ0 | requester 0 won last; requester 1 wins a tie
//  LAST_RQ1 | requester 1 won last (or reset); requester 0 wins a tie
module cmpp_rr_arb
   import cmpp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   rr_state_e state, state_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LAST_RQ1;
      else       state <= state_nxt;
   end

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (state == LAST_RQ1) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Kept apart from the grant decode so accept (derived from grant) cannot form a loop
   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = grant[1] ? LAST_RQ1 : LAST_RQ0;
   end

endmodule

// File: rtl/cmpp_sched.sv
// Two-requester compare scheduler: arbitrates, registers one compare into S1,
// and retires it into the predicate file on the following edge.
module cmpp_sched
   import cmpp_pkg::*;
#(
   parameter  int width = 4,
   parameter  int npred = 8,
   localparam int pw    = $clog2(npred)
)(
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          rq_valid,
   output logic [1:0]          rq_ready,
   input  logic [2*width-1:0]  rq_i0,
   input  logic [2*width-1:0]  rq_i1,
   input  logic [5:0]          rq_op,
   input  logic [1:0]          rq_pred,
   input  logic [2*pw-1:0]     rq_dst0,
   input  logic [2*pw-1:0]     rq_dst1,
   input  logic                stall,
   input  logic                clear,
   output logic [npred-1:0]    pred_q,
   output logic                done_valid,
   output logic                done_id,
   output logic [15:0]         op_cnt
);

   logic [1:0]       grant;
   logic             hold, accept, gid;
   logic [width-1:0] sel_i0, sel_i1;
   logic [2:0]       sel_op;
   logic             sel_pred;
   logic [pw-1:0]    sel_dst0, sel_dst1;

   logic             s1_valid, s1_id, s1_pred;
   logic [width-1:0] s1_i0, s1_i1;
   logic [2:0]       s1_op;
   logic [pw-1:0]    s1_dst0, s1_dst1;

   logic             retire, outt, r0, r1;
   logic [npred-1:0] pred_nxt;

   cmpp_rr_arb u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (rq_valid),
      .accept (accept),
      .grant  (grant)
   );

   assign hold     = stall | clear | reset;
   assign rq_ready = grant & {2{~hold}};
   assign accept   = |rq_ready;
   assign gid      = rq_ready[1];

   assign sel_i0   = gid ? rq_i0[2*width-1:width] : rq_i0[width-1:0];
   assign sel_i1   = gid ? rq_i1[2*width-1:width] : rq_i1[width-1:0];
   assign sel_op   = gid ? rq_op[5:3]             : rq_op[2:0];
   assign sel_pred = gid ? rq_pred[1]             : rq_pred[0];
   assign sel_dst0 = gid ? rq_dst0[2*pw-1:pw]     : rq_dst0[pw-1:0];
   assign sel_dst1 = gid ? rq_dst1[2*pw-1:pw]     : rq_dst1[pw-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_id    <= 1'b0;
         s1_i0    <= '0;
         s1_i1    <= '0;
         s1_op    <= '0;
         s1_pred  <= 1'b0;
         s1_dst0  <= '0;
         s1_dst1  <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else if (!stall) begin
         s1_valid <= accept;
         if (accept) begin
            s1_id   <= gid;
            s1_i0   <= sel_i0;
            s1_i1   <= sel_i1;
            s1_op   <= sel_op;
            s1_pred <= sel_pred;
            s1_dst0 <= sel_dst0;
            s1_dst1 <= sel_dst1;
         end
      end
   end

   assign retire = s1_valid & ~stall & ~clear;
   assign outt   = (s1_i0 != s1_i1);
   assign r0     = cmp_bit(s1_pred, outt, s1_op[OP_INV0_BIT]);
   assign r1     = cmp_bit(s1_pred, outt, s1_op[OP_INV1_BIT]);

   // r1 is written second so it wins when both destinations coincide
   always_comb begin
      pred_nxt = pred_q;
      if (retire && !s1_op[OP_NOP_BIT]) begin
         pred_nxt[s1_dst0] = r0;
         pred_nxt[s1_dst1] = r1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      pred_q <= '0;
      else if (clear) pred_q <= '0;
      else            pred_q <= pred_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_valid <= 1'b0;
         done_id    <= 1'b0;
         op_cnt     <= '0;
      end else begin
         done_valid <= retire;
         if (retire) begin
            done_id <= s1_id;
            if (op_cnt != CNT_MAX) op_cnt <= op_cnt + 16'd1;
         end
      end
   end

endmodule
